// File: rtl/channel_to_pulse.sv
// Converts each word accepted on a valid/accept channel into a fixed-length
// output pulse, followed by an optional idle gap before the next word.
module channel_to_pulse #(
  parameter int N         = 1,
  parameter int PULSE_LEN = 1,
  parameter int GAP       = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_d,
  input  logic         in_v,
  output logic         in_a,
  output logic [N-1:0] data,
  output logic         pulse,
  output logic         busy,
  output logic [15:0]  count
);

  localparam int MAXC = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
  // The down-counter only ever holds values up to MAXC-1.
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    READY   = 2'd0,
    PULSING = 2'd1,
    GAPWAIT = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] counter_reg;
  logic [N-1:0]  data_reg;
  logic          pulse_reg;
  logic [15:0]   count_reg;

  assign in_a  = in_v & (state_reg == READY) & reset;
  assign busy  = (state_reg != READY) | ~reset;
  assign data  = data_reg;
  assign pulse = pulse_reg;
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= READY;
      counter_reg <= '0;
      data_reg    <= '0;
      pulse_reg   <= 1'b0;
      count_reg   <= 16'd0;
    end else begin
      case (state_reg)
        READY: begin
          if (in_v) begin
            data_reg    <= in_d;
            count_reg   <= count_reg + 16'd1;
            counter_reg <= PULSE_LOAD;
            pulse_reg   <= 1'b1;
            state_reg   <= PULSING;
          end
        end
        PULSING: begin
          if (counter_reg != '0) begin
            counter_reg <= counter_reg - 1'b1;
          end else if (GAP > 0) begin
            counter_reg <= GAP_LOAD;
            pulse_reg   <= 1'b0;
            state_reg   <= GAPWAIT;
          end else begin
            pulse_reg   <= 1'b0;
            state_reg   <= READY;
          end
        end
        GAPWAIT: begin
          if (counter_reg != '0) begin
            counter_reg <= counter_reg - 1'b1;
          end else begin
            state_reg   <= READY;
          end
        end
        default: begin
          pulse_reg   <= 1'b0;
          state_reg   <= READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_to_pulse.sv
// Drives several parameterisations of channel_to_pulse with one random stream
// and compares every output, every cycle, against a timeline-based model.
module tb_channel_to_pulse;

  localparam int NI = 4;
  localparam int PLS [NI] = '{1, 3, 4, 7};
  localparam int GPS [NI] = '{0, 2, 1, 5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] in_d;
  logic       in_v;

  logic        a_w     [NI];
  logic [7:0]  data_w  [NI];
  logic        pulse_w [NI];
  logic        busy_w  [NI];
  logic [15:0] count_w [NI];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      channel_to_pulse #(
        .N(8), .PULSE_LEN(PLS[gi]), .GAP(GPS[gi])
      ) u_dut (
        .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(a_w[gi]),
        .data(data_w[gi]), .pulse(pulse_w[gi]), .busy(busy_w[gi]),
        .count(count_w[gi])
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: edge index of last accept, first edge at which a new accept is allowed.
  int          acc_m [NI];
  int          rdy_m [NI];
  logic [7:0]  dat_m [NI];
  logic [15:0] cnt_m [NI];
  int          t = -1;

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    reset = r;
    in_v  = v;
    in_d  = d;
    #1;
    if (t >= 0) begin
      for (int i = 0; i < NI; i++) begin
        bit rdy, ep;
        rdy = (t + 1 >= rdy_m[i]);
        ep  = (t >= acc_m[i]) && (t <= acc_m[i] + PLS[i] - 1);
        chk($sformatf("pulse[%0d]@%0d", i, t), 32'(pulse_w[i]), 32'(ep));
        chk($sformatf("data[%0d]@%0d", i, t), 32'(data_w[i]), 32'(dat_m[i]));
        chk($sformatf("count[%0d]@%0d", i, t), 32'(count_w[i]), 32'(cnt_m[i]));
        chk($sformatf("busy[%0d]@%0d", i, t), 32'(busy_w[i]), 32'(!rdy || !r));
        chk($sformatf("in_a[%0d]@%0d", i, t), 32'(a_w[i]), 32'(v && rdy && r));
      end
    end
    @(posedge clk);
    t++;
    for (int i = 0; i < NI; i++) begin
      if (!r) begin
        rdy_m[i] = t + 1;
        acc_m[i] = -1000;
        dat_m[i] = 8'h00;
        cnt_m[i] = 16'h0000;
      end else if (v && t >= rdy_m[i]) begin
        acc_m[i] = t;
        rdy_m[i] = t + PLS[i] + GPS[i] + 1;
        dat_m[i] = d;
        cnt_m[i] = cnt_m[i] + 16'd1;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    in_v  = 1'b0;
    in_d  = 8'h00;
    for (int i = 0; i < NI; i++) begin
      acc_m[i] = -1000;
      rdy_m[i] = 0;
      dat_m[i] = 8'h00;
      cnt_m[i] = 16'h0000;
    end

    // Reset with valid asserted: nothing may be accepted.
    repeat (3) step(1'b0, 1'b1, 8'($urandom));

    // Back-to-back stream with a fixed word.
    repeat (8) step(1'b1, 1'b1, 8'hA5);

    // Stepping data words held valid through busy periods.
    for (int k = 1; k <= 24; k++) step(1'b1, 1'b1, 8'(k));

    // Random valid, data and occasional resets (hits mid-pulse and mid-gap).
    for (int k = 0; k < 3000; k++)
      step(1'b1 ^ ($urandom_range(0, 49) == 0), $urandom_range(0, 2) != 0, 8'($urandom));

    // Preload instance 0 close to wrap, then stream through the rollover.
    step(1'b1, 1'b0, 8'h00);
    g_dut[0].u_dut.count_reg = 16'hFFF0;
    cnt_m[0] = 16'hFFF0;
    for (int k = 0; k < 60; k++) step(1'b1, 1'b1, 8'($urandom));

    // Reset released with valid high: accepted on that very edge.
    step(1'b0, 1'b1, 8'h3C);
    repeat (6) step(1'b1, 1'b1, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
